// File: rtl/term_writer.sv
// Terminal front-end: turns a UART byte stream into character-cell writes
// and blit commands (clear / scroll) for vga_text_mode.
//
// Ports:
//   clk100, rst        clock, synchronous active-high reset
//   rx_valid/rx_data   incoming byte; rx_ready high only when idle
//   wr_en/addr/data    single-cycle cell write (data = glyph + 1, 0 = blank)
//   blit_en/start/end/offset  blit request; parameters held until next blit
//   blit_complete      done pulse from the display
//   cursor_addr        row*COLS+col of the cursor
module term_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 25,
    parameter int TAB  = 8
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        blit_en,
    output logic [10:0] blit_start,
    output logic [10:0] blit_end,
    output logic [7:0]  blit_offset,
    input  logic        blit_complete,
    output logic [10:0] cursor_addr
);

    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [10:0] SCREEN   = 11'(COLS * ROWS);
    localparam logic [10:0] BODY     = 11'((ROWS - 1) * COLS);
    localparam logic [7:0]  ROW_OFS  = 8'(COLS);

    typedef enum logic [2:0] {
        CLR, CLR_WAIT, IDLE, WRITE,
        SCROLL, SCROLL_WAIT, ROWCLR, ROWCLR_WAIT
    } state_t;

    state_t      state, state_n;
    logic [6:0]  col, col_n;
    logic [4:0]  row, row_n;
    logic        latch;
    logic        go;
    logic [10:0] go_start, go_end;
    logic [7:0]  go_offset;
    logic [7:0]  tab_sum;
    logic [6:0]  tab_col;
    logic        printable;

    // Next tab stop, clamped to the last column.
    assign tab_sum   = {1'b0, col | 7'(TAB - 1)} + 8'd1;
    assign tab_col   = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[6:0];
    assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

    assign rx_ready = (state == IDLE);
    assign wr_en    = (state == WRITE);

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        latch     = 1'b0;
        go        = 1'b0;
        go_start  = '0;
        go_end    = '0;
        go_offset = '0;
        unique case (state)
            CLR: begin
                col_n   = '0;
                row_n   = '0;
                go      = 1'b1;
                go_end  = SCREEN;
                state_n = CLR_WAIT;
            end
            CLR_WAIT: begin
                if (blit_complete) state_n = IDLE;
            end
            IDLE: begin
                if (rx_valid) begin
                    if (printable) begin
                        latch   = 1'b1;
                        state_n = WRITE;
                    end else if (rx_data == 8'h0A) begin
                        if (row < LAST_ROW) row_n = row + 5'd1;
                        else                state_n = SCROLL;
                    end else if (rx_data == 8'h0D) begin
                        col_n = '0;
                    end else if (rx_data == 8'h08) begin
                        if (col != 7'd0) col_n = col - 7'd1;
                    end else if (rx_data == 8'h09) begin
                        col_n = tab_col;
                    end else if (rx_data == 8'h0C) begin
                        state_n = CLR;
                    end
                end
            end
            WRITE: begin
                state_n = IDLE;
                if (col < LAST_COL) begin
                    col_n = col + 7'd1;
                end else begin
                    col_n = '0;
                    if (row < LAST_ROW) row_n = row + 5'd1;
                    else                state_n = SCROLL;
                end
            end
            SCROLL: begin
                go        = 1'b1;
                go_end    = BODY;
                go_offset = ROW_OFS;
                state_n   = SCROLL_WAIT;
            end
            SCROLL_WAIT: begin
                // Row-clear blit is issued on the edge that enters ROWCLR.
                if (blit_complete) begin
                    go       = 1'b1;
                    go_start = BODY;
                    go_end   = SCREEN;
                    state_n  = ROWCLR;
                end
            end
            ROWCLR: begin
                state_n = ROWCLR_WAIT;
            end
            ROWCLR_WAIT: begin
                if (blit_complete) state_n = IDLE;
            end
            default: state_n = CLR;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state       <= CLR;
            col         <= '0;
            row         <= '0;
            cursor_addr <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            blit_en     <= 1'b0;
            blit_start  <= '0;
            blit_end    <= '0;
            blit_offset <= '0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            cursor_addr <= 11'(row_n) * 11'(COLS) + 11'(col_n);
            blit_en     <= go;
            if (go) begin
                blit_start  <= go_start;
                blit_end    <= go_end;
                blit_offset <= go_offset;
            end
            if (latch) begin
                wr_addr <= cursor_addr;
                wr_data <= rx_data + 8'd1;
            end
        end
    end

endmodule
